// File: rtl/demux_1to4_tdm_if.sv
// Link-side bus of the 4-slot TDM demultiplexer.
// The master drives slot samples in and consumes the assembled frame;
// the slave is the demultiplexer itself.
interface demux_1to4_tdm_if #(
    parameter int W     = 1,
    parameter int CNT_W = 8
);
    logic [W-1:0]     din;
    logic             din_valid;
    logic             frame_start;
    logic [4*W-1:0]   y;
    logic             y_valid;
    logic [1:0]       sel;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output din,
        output din_valid,
        output frame_start,
        input  y,
        input  y_valid,
        input  sel,
        input  frame_err,
        input  frame_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_start,
        output y,
        output y_valid,
        output sel,
        output frame_err,
        output frame_cnt
    );
endinterface

// File: rtl/demux_1to4_tdm.sv
// Receive end of a 4-slot TDM link. Locks onto the frame-start marker,
// collects slots 0..2 in a shadow store and publishes the whole frame as
// one parallel word on the edge that samples slot 3. Missing or early
// sync markers raise a one-cycle framing error. All outputs are registered.
module demux_1to4_tdm #(
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    demux_1to4_tdm_if.slave bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [W-1:0]     shadow_q [3];
    logic [W-1:0]     shadow_d [3];
    logic [4*W-1:0]   y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            shadow_q[0] <= '0;
            shadow_q[1] <= '0;
            shadow_q[2] <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q[0] <= shadow_d[0];
            shadow_q[1] <= shadow_d[1];
            shadow_q[2] <= shadow_d[2];
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Slot alignment and frame assembly; only valid beats move anything,
    // while the two pulse outputs fall back to 0 on every non-event cycle.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d[0] = shadow_q[0];
        shadow_d[1] = shadow_q[1];
        shadow_d[2] = shadow_q[2];
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (bus.din_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        shadow_d[0] = bus.din;
                        sel_d       = 2'd1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_start) begin
                        // A marker anywhere but slot 0 abandons the partial frame
                        // and restarts alignment on this very beat.
                        frame_err_d = (sel_q != 2'd0);
                        shadow_d[0] = bus.din;
                        sel_d       = 2'd1;
                    end else begin
                        unique case (sel_q)
                            2'd0: begin
                                frame_err_d = 1'b1;
                                sel_d       = 2'd0;
                                state_d     = IDLE;
                            end
                            2'd1: begin
                                shadow_d[1] = bus.din;
                                sel_d       = 2'd2;
                            end
                            2'd2: begin
                                shadow_d[2] = bus.din;
                                sel_d       = 2'd3;
                            end
                            default: begin
                                y_d         = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                                y_valid_d   = 1'b1;
                                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                                sel_d       = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.sel       = sel_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Testbench for demux_1to4_tdm: directed scenarios plus a random phase,
// every cycle compared against a slot-queue reference model.
module tb_demux_1to4_tdm;

    localparam int W     = 1;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_1to4_tdm_if #(.W(W), .CNT_W(CNT_W)) bus ();

    demux_1to4_tdm #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: aligned flag plus the samples of the frame in progress.
    bit               aligned;
    logic [W-1:0]     part [$];
    logic [4*W-1:0]   expY;
    logic             expYValid;
    logic             expErr;
    logic [CNT_W-1:0] expCnt;

    int cycle     = 0;
    int pulses    = 0;
    int lastPulse = -1;
    int badGap    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        aligned   = 1'b0;
        part.delete();
        expY      = '0;
        expYValid = 1'b0;
        expErr    = 1'b0;
        expCnt    = '0;
    endtask

    task automatic modelBeat(input logic [W-1:0] d, input logic v, input logic fs);
        expYValid = 1'b0;
        expErr    = 1'b0;
        if (!v) return;
        if (!aligned) begin
            if (fs) begin
                part.delete();
                part.push_back(d);
                aligned = 1'b1;
            end
        end else if (fs) begin
            if (part.size() != 0) expErr = 1'b1;
            part.delete();
            part.push_back(d);
        end else if (part.size() == 0) begin
            expErr  = 1'b1;
            aligned = 1'b0;
        end else begin
            part.push_back(d);
            if (part.size() == 4) begin
                for (int k = 0; k < 4; k++) expY[k*W +: W] = part[k];
                expYValid = 1'b1;
                expCnt    = expCnt + 1'b1;
                part.delete();
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("y",         32'(bus.y),         32'(expY));
        checkOutput("y_valid",   32'(bus.y_valid),   32'(expYValid));
        checkOutput("sel",       32'(bus.sel),       32'(part.size()));
        checkOutput("frame_err", 32'(bus.frame_err), 32'(expErr));
        checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(expCnt));
        checkOutput("exclusive", 32'(bus.y_valid & bus.frame_err), 32'd0);
    endtask

    // Called at a falling edge: drive one cycle, check just after the rising edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic fs);
        bus.din         = d;
        bus.din_valid   = v;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        cycle++;
        modelBeat(d, v, fs);
        checkAll();
        if (bus.y_valid === 1'b1) begin
            pulses++;
            if (lastPulse >= 0 && (cycle - lastPulse) != 4) badGap++;
            lastPulse = cycle;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        rst = 1'b1;
        #2;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sendFrame(input logic [3:0] bits);
        for (int s = 0; s < 4; s++) applyStimulus(W'(bits[s]), 1'b1, s == 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired=1 required=0");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        modelReset();
        @(negedge clk);

        // Basic frame: din 1,0,1,1 -> y = 4'b1101
        doReset();
        sendFrame(4'b1101);
        checkOutput("t1_y", 32'(bus.y), 32'h0000000d);
        checkOutput("t1_cnt", 32'(bus.frame_cnt), 32'd1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t1_y_hold", 32'(bus.y), 32'h0000000d);

        // Same frame with a two-cycle gap between slots 1 and 2
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t2_sel_gap", 32'(bus.sel), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t2_y", 32'(bus.y), 32'h0000000d);
        checkOutput("t2_valid", 32'(bus.y_valid), 32'd1);

        // Early sync on the third beat restarts the frame
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3_err", 32'(bus.frame_err), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_y", 32'(bus.y), 32'd0);
        checkOutput("t3_valid", 32'(bus.y_valid), 32'd1);
        checkOutput("t3_cnt", 32'(bus.frame_cnt), 32'd1);

        // Missing sync after a complete frame drops to IDLE until the marker returns
        doReset();
        sendFrame(4'b1101);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_err", 32'(bus.frame_err), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_y_kept", 32'(bus.y), 32'h0000000d);
        checkOutput("t4_sel_idle", 32'(bus.sel), 32'd0);
        sendFrame(4'b0100);
        checkOutput("t4_y_next", 32'(bus.y), 32'h00000004);
        checkOutput("t4_cnt", 32'(bus.frame_cnt), 32'd2);

        // 256 back-to-back frames wrap the counter
        doReset();
        pulses    = 0;
        lastPulse = -1;
        badGap    = 0;
        for (int f = 0; f < 256; f++) sendFrame(4'($urandom));
        checkOutput("t5_pulses", 32'(pulses), 32'd256);
        checkOutput("t5_gaps", 32'(badGap), 32'd0);
        checkOutput("t5_cnt_wrap", 32'(bus.frame_cnt), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++)
            applyStimulus(W'($urandom), ($urandom % 4) != 0, ($urandom % 4) == 0);

        // Asynchronous reset mid-frame
        doReset();
        sendFrame(4'b1111);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("t6_y_zero", 32'(bus.y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sendFrame(4'b1101);
        checkOutput("t6_y", 32'(bus.y), 32'h0000000d);
        checkOutput("t6_cnt", 32'(bus.frame_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
